// File: rtl/eforth1_pkg.sv
// rtl/eforth1_pkg.sv - shared state encoding and defaults for the outer interpreter
package eforth1_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FND,
        EXE,
        CMA,
        A2I,
        LIT,
        PSH,
        ERR
    } state_t;

    localparam int unsigned OP_LIT_DEF = 'h0;

endpackage

// File: rtl/outer_seq_if.sv
// rtl/outer_seq_if.sv - control, finder, atoi, execute, memory and stack bundle of outer_seq
interface outer_seq_if #(
    parameter int MSZ = 8,
    parameter int DSZ = 32,
    parameter int ASZ = 17
);
    logic           start;
    logic [ASZ-1:0] here0;
    logic           compile;
    logic           busy;
    logic           done;
    logic [ASZ-1:0] here;
    logic           fdr_req;
    logic [ASZ-1:0] fdr_tib;
    logic           fdr_done;
    logic           fdr_hit;
    logic           fdr_empty;
    logic           fdr_imm;
    logic [MSZ-1:0] fdr_op;
    logic [ASZ-1:0] fdr_nxt;
    logic           a2i_req;
    logic [ASZ-1:0] a2i_tib;
    logic           a2i_done;
    logic           a2i_err;
    logic [DSZ-1:0] a2i_val;
    logic [ASZ-1:0] a2i_nxt;
    logic           exe_req;
    logic [MSZ-1:0] exe_op;
    logic           exe_done;
    logic           mwe;
    logic [ASZ-1:0] mai;
    logic [MSZ-1:0] mvi;
    logic           ss_push;
    logic [DSZ-1:0] ss_val;
    logic           err;
    logic [ASZ-1:0] err_tib;

    modport master (
        input  start, here0, compile,
        output busy, done, here,
        output fdr_req, fdr_tib,
        input  fdr_done, fdr_hit, fdr_empty, fdr_imm, fdr_op, fdr_nxt,
        output a2i_req, a2i_tib,
        input  a2i_done, a2i_err, a2i_val, a2i_nxt,
        output exe_req, exe_op,
        input  exe_done,
        output mwe, mai, mvi, ss_push, ss_val, err, err_tib
    );

    modport slave (
        output start, here0, compile,
        input  busy, done, here,
        input  fdr_req, fdr_tib,
        output fdr_done, fdr_hit, fdr_empty, fdr_imm, fdr_op, fdr_nxt,
        input  a2i_req, a2i_tib,
        output a2i_done, a2i_err, a2i_val, a2i_nxt,
        input  exe_req, exe_op,
        output exe_done,
        input  mwe, mai, mvi, ss_push, ss_val, err, err_tib
    );

endinterface

// File: rtl/outer_seq_lit_emitter.sv
// rtl/outer_seq_lit_emitter.sv - serialises OP_LIT then a little-endian value, one byte per step
module lit_emitter #(
    parameter int MSZ = 8,
    parameter int DSZ = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           step,
    input  logic [DSZ-1:0] value,
    input  logic [MSZ-1:0] op_lit,
    output logic [MSZ-1:0] byte_out,
    output logic           last
);
    localparam int NB = DSZ / MSZ;
    localparam int CW = $clog2(NB + 1);

    logic [DSZ+MSZ-1:0] sr;
    logic [CW-1:0]      cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= {value, op_lit};
            cnt <= '0;
        end else if (step) begin
            sr  <= {{MSZ{1'b0}}, sr[DSZ+MSZ-1:MSZ]};
            cnt <= cnt + CW'(1);
        end
    end

    assign byte_out = sr[MSZ-1:0];
    assign last     = (cnt == CW'(NB));

endmodule

// File: rtl/outer_seq.sv
// rtl/outer_seq.sv - Forth outer interpreter sequencer; OUTER_IMMEDIATE_EN runs immediate words while compiling
module outer_seq
    import eforth1_pkg::*;
#(
    parameter int unsigned TIB    = 'h0,
    parameter int          MSZ    = 8,
    parameter int          DSZ    = 32,
    parameter int          ASZ    = 17,
    parameter int unsigned OP_LIT = OP_LIT_DEF
) (
    input logic       clk,
    input logic       rst,
    outer_seq_if.master bus
);
    logic [1:0] rst_sync;
    logic       rst_n;

    // Assert asynchronously, release only on a clock edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= 2'b00;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    state_t         state;
    logic [ASZ-1:0] tib, tok, here, err_tib_q;
    logic [MSZ-1:0] op, lit_byte;
    logic [DSZ-1:0] val;
    logic           cmp, busy_q, done_q, err_q;
    logic           fdr_req_q, a2i_req_q, exe_req_q, mwe_q, push_q;
    logic           exec_mode, lit_load, lit_last;

`ifdef OUTER_IMMEDIATE_EN
    assign exec_mode = !bus.compile || bus.fdr_imm;
`else
    logic unused_imm;
    assign unused_imm = bus.fdr_imm;
    assign exec_mode  = !bus.compile;
`endif

    assign lit_load = (state == A2I) && bus.a2i_done && !bus.a2i_err && cmp;

    lit_emitter #(.MSZ(MSZ), .DSZ(DSZ)) u_lit (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lit_load),
        .step     (state == LIT),
        .value    (bus.a2i_val),
        .op_lit   (MSZ'(OP_LIT)),
        .byte_out (lit_byte),
        .last     (lit_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tib       <= '0;
            tok       <= '0;
            here      <= '0;
            op        <= '0;
            val       <= '0;
            cmp       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_tib_q <= '0;
            fdr_req_q <= 1'b0;
            a2i_req_q <= 1'b0;
            exe_req_q <= 1'b0;
            mwe_q     <= 1'b0;
            push_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    tib       <= ASZ'(TIB);
                    here      <= bus.here0;
                    err_q     <= 1'b0;
                    busy_q    <= 1'b1;
                    fdr_req_q <= 1'b1;
                    state     <= FND;
                end
                FND: if (bus.fdr_done) begin
                    fdr_req_q <= 1'b0;
                    tib       <= bus.fdr_nxt;
                    tok       <= tib;
                    op        <= bus.fdr_op;
                    cmp       <= bus.compile;
                    if (bus.fdr_empty) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end else if (bus.fdr_hit && exec_mode) begin
                        exe_req_q <= 1'b1;
                        state     <= EXE;
                    end else if (bus.fdr_hit) begin
                        mwe_q <= 1'b1;
                        state <= CMA;
                    end else begin
                        a2i_req_q <= 1'b1;
                        state     <= A2I;
                    end
                end
                EXE: if (bus.exe_done) begin
                    exe_req_q <= 1'b0;
                    fdr_req_q <= 1'b1;
                    state     <= FND;
                end
                CMA: begin
                    mwe_q     <= 1'b0;
                    here      <= here + ASZ'(1);
                    fdr_req_q <= 1'b1;
                    state     <= FND;
                end
                A2I: if (bus.a2i_done) begin
                    a2i_req_q <= 1'b0;
                    if (bus.a2i_err) begin
                        state <= ERR;
                    end else begin
                        tib <= bus.a2i_nxt;
                        val <= bus.a2i_val;
                        if (cmp) begin
                            mwe_q <= 1'b1;
                            state <= LIT;
                        end else begin
                            push_q <= 1'b1;
                            state  <= PSH;
                        end
                    end
                end
                PSH: begin
                    push_q    <= 1'b0;
                    fdr_req_q <= 1'b1;
                    state     <= FND;
                end
                LIT: begin
                    here <= here + ASZ'(1);
                    if (lit_last) begin
                        mwe_q     <= 1'b0;
                        fdr_req_q <= 1'b1;
                        state     <= FND;
                    end
                end
                ERR: begin
                    err_q     <= 1'b1;
                    err_tib_q <= tok;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.here    = here;
    assign bus.fdr_req = fdr_req_q;
    assign bus.fdr_tib = tib;
    assign bus.a2i_req = a2i_req_q;
    assign bus.a2i_tib = tok;
    assign bus.exe_req = exe_req_q;
    assign bus.exe_op  = op;
    assign bus.mwe     = mwe_q;
    assign bus.mai     = here;
    assign bus.mvi     = (state == LIT) ? lit_byte : op;
    assign bus.ss_push = push_q;
    assign bus.ss_val  = val;
    assign bus.err     = err_q;
    assign bus.err_tib = err_tib_q;

endmodule

// File: tb/tb_outer_seq.sv
// tb/tb_outer_seq.sv - directed scoreboard bench for outer_seq
module tb_outer_seq;
    localparam int MSZ = 8;
    localparam int DSZ = 32;
    localparam int ASZ = 17;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [ASZ+MSZ-1:0] mem_q[$];
    logic [DSZ-1:0]     stk_q[$];

    outer_seq_if #(.MSZ(MSZ), .DSZ(DSZ), .ASZ(ASZ)) bus ();

    outer_seq #(.OP_LIT('h01)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("req_exclusive", 64'($countones({bus.fdr_req, bus.a2i_req, bus.exe_req, bus.mwe, bus.ss_push})) <= 1, 1);
        if (bus.mwe === 1'b1) begin
            if (mem_q.size() == 0) chk("mem_unexpected", 0, 1);
            else chk("mem_write", {bus.mai, bus.mvi}, mem_q.pop_front());
        end
        if (bus.ss_push === 1'b1) begin
            if (stk_q.size() == 0) chk("push_unexpected", 0, 1);
            else chk("push_val", bus.ss_val, stk_q.pop_front());
        end
    end

    task automatic start_line(input logic [ASZ-1:0] h0, input logic cm);
        @(negedge clk);
        bus.start = 1'b1; bus.here0 = h0; bus.compile = cm;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_start", bus.busy, 1);
    endtask

    task automatic finder(input logic empty, input logic hit, input logic imm,
                          input logic [MSZ-1:0] op, input logic [ASZ-1:0] nxt, input logic [ASZ-1:0] exp_tib);
        int n = 0;
        while (bus.fdr_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("fdr_req", bus.fdr_req, 1);
        chk("fdr_tib", bus.fdr_tib, exp_tib);
        bus.fdr_done = 1'b1; bus.fdr_empty = empty; bus.fdr_hit = hit;
        bus.fdr_imm = imm; bus.fdr_op = op; bus.fdr_nxt = nxt;
        @(negedge clk);
        bus.fdr_done = 1'b0; bus.fdr_empty = 1'b0; bus.fdr_hit = 1'b0; bus.fdr_imm = 1'b0;
    endtask

    task automatic atoi(input logic err, input logic [DSZ-1:0] val, input logic [ASZ-1:0] nxt,
                        input logic [ASZ-1:0] exp_tib);
        int n = 0;
        while (bus.a2i_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("a2i_req", bus.a2i_req, 1);
        chk("a2i_tib", bus.a2i_tib, exp_tib);
        bus.a2i_done = 1'b1; bus.a2i_err = err; bus.a2i_val = val; bus.a2i_nxt = nxt;
        @(negedge clk);
        bus.a2i_done = 1'b0; bus.a2i_err = 1'b0;
    endtask

    task automatic execute(input logic [MSZ-1:0] exp_op);
        int n = 0;
        while (bus.exe_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("exe_req", bus.exe_req, 1);
        chk("exe_op", bus.exe_op, exp_op);
        bus.exe_done = 1'b1;
        @(negedge clk);
        bus.exe_done = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (bus.done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("done_pulse", bus.done, 1);
        chk("busy_at_done", bus.busy, 0);
        @(negedge clk);
        chk("done_one_cycle", bus.done, 0);
    endtask

    initial begin
        int n;
        bus.start = 0; bus.here0 = '0; bus.compile = 0;
        bus.fdr_done = 0; bus.fdr_hit = 0; bus.fdr_empty = 0; bus.fdr_imm = 0; bus.fdr_op = '0; bus.fdr_nxt = '0;
        bus.a2i_done = 0; bus.a2i_err = 0; bus.a2i_val = '0; bus.a2i_nxt = '0; bus.exe_done = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_err_tib", bus.err_tib, 0);
        chk("rst_here", bus.here, 0);
        chk("rst_reqs", {bus.fdr_req, bus.a2i_req, bus.exe_req, bus.mwe, bus.ss_push}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Execute "5" then end of line
        start_line('h40, 0);
        finder(0, 0, 0, 'h00, 'h2, 'h0);
        stk_q.push_back(32'd5);
        atoi(0, 32'd5, 'h2, 'h0);
        finder(1, 0, 0, 'h00, 'h2, 'h2);
        wait_done();
        chk("exec_num_here", bus.here, 'h40);
        chk("exec_num_stack_drained", stk_q.size(), 0);

        // Compile a found word
        start_line('h100, 1);
        mem_q.push_back({17'h100, 8'h12});
        finder(0, 1, 0, 'h12, 'h4, 'h0);
        finder(1, 0, 0, 'h00, 'h4, 'h4);
        wait_done();
        chk("comma_here", bus.here, 'h101);

        // Compile a number; compile drops mid-token and must not matter
        start_line('h200, 1);
        finder(0, 0, 0, 'h00, 'h9, 'h0);
        bus.compile = 0;
        mem_q.push_back({17'h200, 8'h01}); mem_q.push_back({17'h201, 8'h44});
        mem_q.push_back({17'h202, 8'h33}); mem_q.push_back({17'h203, 8'h22});
        mem_q.push_back({17'h204, 8'h11});
        atoi(0, 32'h11223344, 'h9, 'h0);
        finder(1, 0, 0, 'h00, 'h9, 'h9);
        wait_done();
        chk("lit_here", bus.here, 'h205);
        chk("lit_mem_drained", mem_q.size(), 0);

        // Executed word then a bad number at 'h003
        start_line('h10, 0);
        finder(0, 1, 0, 'h20, 'h3, 'h0);
        execute('h20);
        finder(0, 0, 0, 'h00, 'h7, 'h3);
        atoi(1, 32'd0, 'h7, 'h3);
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("err_done", bus.done, 1);
        chk("err_flag", bus.err, 1);
        chk("err_tib", bus.err_tib, 'h3);
        chk("err_busy", bus.busy, 0);
        repeat (2) @(negedge clk);
        chk("err_sticky", bus.err, 1);
        start_line('h10, 0);
        chk("err_cleared", bus.err, 0);
        finder(1, 0, 0, 'h00, 'h0, 'h0);
        wait_done();

        // Immediate word while compiling
        start_line('h400, 1);
`ifdef OUTER_IMMEDIATE_EN
        finder(0, 1, 1, 'h33, 'h5, 'h0);
        execute('h33);
        finder(1, 0, 0, 'h00, 'h5, 'h5);
        wait_done();
        chk("imm_here", bus.here, 'h400);
`else
        mem_q.push_back({17'h400, 8'h33});
        finder(0, 1, 1, 'h33, 'h5, 'h0);
        chk("imm_no_exe", bus.exe_req, 0);
        finder(1, 0, 0, 'h00, 'h5, 'h5);
        wait_done();
        chk("imm_here", bus.here, 'h401);
`endif

        // Reset while the third LIT byte is on the bus
        start_line('h300, 1);
        finder(0, 0, 0, 'h00, 'h5, 'h0);
        mem_q.push_back({17'h300, 8'h01}); mem_q.push_back({17'h301, 8'hDD});
        mem_q.push_back({17'h302, 8'hCC});
        atoi(0, 32'hAABBCCDD, 'h5, 'h0);
        n = 0;
        while (!(bus.mwe === 1'b1 && bus.mai === 17'h302) && n < 20) begin @(negedge clk); n++; end
        chk("lit_byte2_seen", bus.mai, 'h302);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_mwe", bus.mwe, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_here", bus.here, 0);
        @(negedge clk);
        chk("abort_reqs", {bus.fdr_req, bus.a2i_req, bus.exe_req, bus.mwe, bus.ss_push}, 0);
        chk("abort_mem_drained", mem_q.size(), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_abort_idle", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/outer_seq.md
OUTER_SEQ -- requirements
Module: outer_seq

Interface
REQ-001 SHALL have parameters: TIB 'h0, TIB base; MSZ 8, memory byte width; DSZ 32, data width (multiple of MSZ); ASZ 17, address width; OP_LIT 'h0, literal opcode compiled before numbers.
REQ-002 SHALL have ports: clk in 1, sole clock; rst in 1, asynchronous active-low reset.
REQ-003 SHALL have ports: start in 1, begin line; here0 in ASZ, dictionary top loaded at start; compile in 1, compile mode; busy out 1; done out 1, one-cycle end-of-line pulse; here out ASZ, current dictionary top.
REQ-004 SHALL have finder ports: fdr_req out 1; fdr_tib out ASZ, scan start; fdr_done in 1; fdr_hit in 1; fdr_empty in 1, no token left; fdr_imm in 1, immediate word; fdr_op in MSZ, opcode; fdr_nxt in ASZ, tib after token.
REQ-005 SHALL have atoi ports: a2i_req out 1; a2i_tib out ASZ; a2i_done in 1; a2i_err in 1; a2i_val in DSZ; a2i_nxt in ASZ.
REQ-006 SHALL have execute ports: exe_req out 1; exe_op out MSZ; exe_done in 1.
REQ-007 SHALL have memory write ports: mwe out 1; mai out ASZ; mvi out MSZ.
REQ-008 SHALL have stack ports: ss_push out 1; ss_val out DSZ.
REQ-009 SHALL have error ports: err out 1, sticky; err_tib out ASZ, token start of failure.

Function
REQ-010 SHALL implement states IDLE, FND, EXE, CMA, A2I, LIT, PSH, ERR.
REQ-011 SHALL in IDLE on start: tib<=TIB, here<=here0, err<=0, go FND; start in any other state ignored.
REQ-012 SHALL hold fdr_req high with fdr_tib=tib throughout FND until fdr_done; same level-held req rule for a2i_req and exe_req.
REQ-013 SHALL on fdr_done: tib<=fdr_nxt; empty -> IDLE with done pulse next cycle; hit and exec-mode -> EXE; hit and compile -> CMA; miss -> A2I with a2i_tib = token start.
REQ-014 SHALL treat exec-mode as !compile, or (compile and fdr_imm) when OUTER_IMMEDIATE_EN defined.
REQ-015 SHALL latch fdr_op into exe_op/comma data on fdr_done; EXE returns to FND on exe_done.
REQ-016 SHALL in CMA drive one write cycle mwe=1, mai=here, mvi=opcode, then here<=here+1, go FND.
REQ-017 SHALL on a2i_done with a2i_err go ERR; else tib<=a2i_nxt, value latched, compile -> LIT, else PSH.
REQ-018 SHALL in PSH pulse ss_push one cycle with ss_val=value, go FND.
REQ-019 SHALL in LIT write 1+DSZ/MSZ bytes, one per cycle at consecutive here: OP_LIT first, then value little-endian; here advanced each byte; go FND after last.
REQ-020 SHALL wrap here and tib modulo 2^ASZ with no flag.
REQ-021 SHALL in ERR set err=1, err_tib=failing token start, pulse done, return to IDLE; err holds until next accepted start.
REQ-022 SHALL keep mwe, ss_push, and all req outputs 0 outside their states; busy=1 in every state except IDLE.
REQ-023 SHALL sample compile once per token at fdr_done; changes mid-token do not affect it.
REQ-024 SHALL allow fdr_done on the first FND cycle (zero wait).

Reset
REQ-025 SHALL on rst low, at any time, force IDLE, busy=0, done=0, err=0, err_tib=0, here=0, all req/mwe/ss_push=0, aborting any operation.
REQ-026 SHALL drop reset synchronously to clk internally before release.

Configuration
REQ-027 SHALL, with OUTER_IMMEDIATE_EN defined, execute immediate words in compile mode; undefined, ignore fdr_imm and compile them.

Structure
REQ-028 SHALL place the state enum and OP_LIT default in shared package eforth1_pkg.
REQ-029 SHALL implement LIT byte serialisation as sub-module lit_emitter (byte counter, shift register).

Verification
REQ-030 Exec "5" then empty: a2i_val=5 -> one ss_push, ss_val=5, then done, here unchanged.
REQ-031 Compile hit op='h12 at here0='h100 -> write 'h100='h12, here='h101.
REQ-032 Compile number 'h11223344, OP_LIT='h01, here0='h200 -> bytes 01,44,33,22,11 at 'h200-'h204, here='h205.
REQ-033 a2i_err on token at 'h003 -> err=1, err_tib='h003, done pulse, busy=0; next start clears err.
REQ-034 rst low during LIT byte 2 -> next cycle IDLE, mwe=0, busy=0.
REQ-035 Compile, fdr_imm=1 -> EXE with macro, CMA without.
